// File: rtl/primitives_pkg.sv
// Shared widths, skid-stage state encoding and the one-hot encode function
// used by encoder_8 and its skid buffer.
package primitives_pkg;

  localparam int IN_WIDTH   = 8;
  localparam int CODE_WIDTH = 3;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_e;

  // Returns {err, code}. err is set unless exactly one bit is set; on a
  // multi-hot word prio_high picks the highest set bit, else the lowest.
  function automatic logic [CODE_WIDTH:0] encode_onehot(
    input logic [IN_WIDTH-1:0] w,
    input logic                prio_high
  );
    logic [CODE_WIDTH-1:0] code;
    logic                  found;
    logic [3:0]            ones;
    code  = '0;
    found = 1'b0;
    ones  = '0;
    for (int i = 0; i < IN_WIDTH; i++) begin
      if (w[i]) begin
        ones = ones + 4'd1;
        if (prio_high || !found) code = i[CODE_WIDTH-1:0];
        found = 1'b1;
      end
    end
    return {(ones != 4'd1), code};
  endfunction

endpackage

// File: rtl/skid_buffer_2.sv
// Generic 2-entry valid/ready skid stage: output register plus one skid slot,
// strictly FIFO, with a registered ready.
module skid_buffer_2
  import primitives_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         s_rst_n_i,
  input  logic [W-1:0] in_data_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  output logic [W-1:0] out_data_o,
  output logic         out_valid_o,
  input  logic         out_ready_i
);

  skid_state_e  state_q, state_d;
  logic [W-1:0] or_q, or_d;
  logic [W-1:0] sk_q, sk_d;
  logic         ready_q;
  logic         acc, xfer;

  assign acc         = in_valid_i & ready_q;
  assign xfer        = out_valid_o & out_ready_i;
  assign in_ready_o  = ready_q;
  assign out_valid_o = (state_q != EMPTY);
  assign out_data_o  = or_q;

  always_comb begin
    state_d = state_q;
    or_d    = or_q;
    sk_d    = sk_q;
    case (state_q)
      EMPTY: if (acc) begin
        or_d    = in_data_i;
        state_d = ONE;
      end
      ONE: begin
        if (acc && xfer) begin
          or_d = in_data_i;
        end else if (acc) begin
          sk_d    = in_data_i;
          state_d = TWO;
        end else if (xfer) begin
          state_d = EMPTY;
        end
      end
      // ready_q is low here, so only the drain path exists
      TWO: if (xfer) begin
        or_d    = sk_q;
        state_d = ONE;
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!s_rst_n_i) begin
      state_q <= EMPTY;
      or_q    <= '0;
      sk_q    <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      or_q    <= or_d;
      sk_q    <= sk_d;
      ready_q <= (state_d != TWO);
    end
  end

endmodule

// File: rtl/encoder_8.sv
// Registered 8-to-3 one-hot encoder with valid/ready skid buffering, a
// per-beat error flag and a saturating error counter.
module encoder_8
  import primitives_pkg::*;
#(
  parameter int PRIORITY_HIGH = 1,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     s_rst_n_i,
  input  logic [IN_WIDTH-1:0]      data_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  output logic                     data_0_o,
  output logic                     data_1_o,
  output logic                     data_2_o,
  output logic                     error_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  input  logic                     err_clr_i,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt_o
);

  logic [CODE_WIDTH:0]        enc;
  logic [CODE_WIDTH:0]        out_pl;
  logic                       acc;
  logic [ERR_CNT_WIDTH-1:0]   cnt_q, cnt_d;

  // Code and error are resolved at accept time and travel as payload
  assign enc = encode_onehot(data_i, (PRIORITY_HIGH != 0));
  assign acc = valid_i & ready_o;

  skid_buffer_2 #(.W(CODE_WIDTH + 1)) u_skid (
    .clk_i       (clk_i),
    .s_rst_n_i   (s_rst_n_i),
    .in_data_i   (enc),
    .in_valid_i  (valid_i),
    .in_ready_o  (ready_o),
    .out_data_o  (out_pl),
    .out_valid_o (valid_o),
    .out_ready_i (ready_i)
  );

  // data_0_o carries weight 4 to match the decoder's input mapping
  assign error_o  = out_pl[3];
  assign data_0_o = out_pl[2];
  assign data_1_o = out_pl[1];
  assign data_2_o = out_pl[0];

  always_comb begin
    cnt_d = cnt_q;
    if (err_clr_i)
      cnt_d = '0;
    else if (acc && enc[CODE_WIDTH] && !(&cnt_q))
      cnt_d = cnt_q + {{(ERR_CNT_WIDTH-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk_i) begin
    if (!s_rst_n_i) cnt_q <= '0;
    else            cnt_q <= cnt_d;
  end

  assign err_cnt_o = cnt_q;

endmodule

// File: tb/tb_encoder_8.sv
// Bench for encoder_8: three parameterizations share one stimulus stream and
// are checked each cycle against a queue-based model plus literal spot checks.
module tb_encoder_8;

  logic       clk = 1'b0, rst_n = 1'b0, vld = 1'b0, rdy = 1'b0, clr = 1'b0;
  logic [7:0] din = 8'h00;

  logic       hi_r, hi_0, hi_1, hi_2, hi_e, hi_v;
  logic       lo_r, lo_0, lo_1, lo_2, lo_e, lo_v;
  logic       st_r, st_0, st_1, st_2, st_e, st_v;
  logic [7:0] hi_c, lo_c;
  logic [1:0] st_c;

  encoder_8 #(.PRIORITY_HIGH(1), .ERR_CNT_WIDTH(8)) u_hi (
    .clk_i(clk), .s_rst_n_i(rst_n), .data_i(din), .valid_i(vld), .ready_o(hi_r),
    .data_0_o(hi_0), .data_1_o(hi_1), .data_2_o(hi_2), .error_o(hi_e),
    .valid_o(hi_v), .ready_i(rdy), .err_clr_i(clr), .err_cnt_o(hi_c));
  encoder_8 #(.PRIORITY_HIGH(0), .ERR_CNT_WIDTH(8)) u_lo (
    .clk_i(clk), .s_rst_n_i(rst_n), .data_i(din), .valid_i(vld), .ready_o(lo_r),
    .data_0_o(lo_0), .data_1_o(lo_1), .data_2_o(lo_2), .error_o(lo_e),
    .valid_o(lo_v), .ready_i(rdy), .err_clr_i(clr), .err_cnt_o(lo_c));
  encoder_8 #(.PRIORITY_HIGH(1), .ERR_CNT_WIDTH(2)) u_sat (
    .clk_i(clk), .s_rst_n_i(rst_n), .data_i(din), .valid_i(vld), .ready_o(st_r),
    .data_0_o(st_0), .data_1_o(st_1), .data_2_o(st_2), .error_o(st_e),
    .valid_o(st_v), .ready_i(rdy), .err_clr_i(clr), .err_cnt_o(st_c));

  always #5 clk = ~clk;

  int vec = 0, bad = 0;

  logic [7:0] mq[$];
  bit         m_rdy = 1'b0;
  int         m_cnt = 0, m_cnt_sat = 0;

  function automatic bit m_err(input logic [7:0] w);
    return $countones(w) != 1;
  endfunction

  function automatic int m_code(input logic [7:0] w, input bit ph);
    int c;
    c = 0;
    if (ph) begin
      for (int i = 7; i >= 0; i--) if (w[i]) begin c = i; break; end
    end else begin
      for (int i = 0; i < 8; i++) if (w[i]) begin c = i; break; end
    end
    return c;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Model: a 2-deep FIFO whose ready reflects the occupancy after the last edge
  always @(posedge clk) begin
    if (!rst_n) begin
      mq.delete();
      m_rdy = 1'b0;
      m_cnt = 0;
      m_cnt_sat = 0;
    end else begin
      bit acc, xfer;
      acc  = vld && m_rdy;
      xfer = (mq.size() > 0) && rdy;
      if (xfer) void'(mq.pop_front());
      if (acc) mq.push_back(din);
      if (clr) begin
        m_cnt = 0;
        m_cnt_sat = 0;
      end else if (acc && m_err(din)) begin
        if (m_cnt < 255) m_cnt++;
        if (m_cnt_sat < 3) m_cnt_sat++;
      end
      m_rdy = (mq.size() < 2);
    end
  end

  task automatic cmp_inst(input string nm, input logic v, input logic r,
                          input logic [2:0] code, input logic e,
                          input logic [31:0] cnt, input bit ph, input int ecnt);
    chk({nm, ".valid"}, v, mq.size() > 0);
    chk({nm, ".ready"}, r, m_rdy);
    chk({nm, ".errcnt"}, cnt, ecnt);
    if (mq.size() > 0) begin
      chk({nm, ".code"}, code, m_code(mq[0], ph));
      chk({nm, ".error"}, e, m_err(mq[0]));
    end
  endtask

  always @(negedge clk) begin
    cmp_inst("hi", hi_v, hi_r, {hi_0, hi_1, hi_2}, hi_e, hi_c, 1'b1, m_cnt);
    cmp_inst("lo", lo_v, lo_r, {lo_0, lo_1, lo_2}, lo_e, lo_c, 1'b0, m_cnt);
    cmp_inst("sat", st_v, st_r, {st_0, st_1, st_2}, st_e, st_c, 1'b1, m_cnt_sat);
    // Round trip through a 3-to-8 decode of the output index
    if (mq.size() > 0 && !m_err(mq[0]))
      chk("roundtrip", 8'h01 << {hi_0, hi_1, hi_2}, mq[0]);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) cyc();
    chk("rst.ready", hi_r, 1'b0);
    chk("rst.valid", hi_v, 1'b0);
    chk("rst.errcnt", hi_c, 8'd0);
    rst_n = 1'b1;
    cyc();
    chk("post_rst.ready", hi_r, 1'b1);

    rdy = 1'b1;
    for (int k = 0; k < 8; k++) begin
      din = 8'h01 << k;
      vld = 1'b1;
      cyc();
      chk("sweep.code", {hi_0, hi_1, hi_2}, k);
      chk("sweep.error", hi_e, 1'b0);
    end
    vld = 1'b0;
    cyc();
    chk("sweep.errcnt", hi_c, 8'd0);
    chk("sweep.drained", hi_v, 1'b0);

    vld = 1'b1; din = 8'h00;
    cyc();
    chk("zero.code", {hi_0, hi_1, hi_2}, 3'd0);
    chk("zero.error", hi_e, 1'b1);
    din = 8'h81;
    cyc();
    chk("multi.hi_code", {hi_0, hi_1, hi_2}, 3'd7);
    chk("multi.lo_code", {lo_0, lo_1, lo_2}, 3'd0);
    chk("multi.error", hi_e, 1'b1);
    vld = 1'b0;
    cyc();
    chk("err.errcnt", hi_c, 8'd2);

    rdy = 1'b0; vld = 1'b1; din = 8'h04;
    cyc();
    din = 8'h10;
    cyc();
    vld = 1'b0;
    chk("bp.ready_low", hi_r, 1'b0);
    chk("bp.hold_code", {hi_0, hi_1, hi_2}, 3'd2);
    cyc();
    chk("bp.still_code", {hi_0, hi_1, hi_2}, 3'd2);
    rdy = 1'b1;
    cyc();
    chk("bp.second_code", {hi_0, hi_1, hi_2}, 3'd4);
    chk("bp.ready_back", hi_r, 1'b1);
    cyc();
    chk("bp.empty", hi_v, 1'b0);

    clr = 1'b1;
    cyc();
    clr = 1'b0;
    chk("sat.cleared", st_c, 2'd0);
    vld = 1'b1; din = 8'h03;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("sat.count", st_c, (i + 1 > 3) ? 3 : i + 1);
    end
    chk("sat.wide_count", hi_c, 8'd5);
    clr = 1'b1;
    cyc();
    chk("sat.clr_wins", st_c, 2'd0);
    chk("sat.clr_wins_wide", hi_c, 8'd0);
    clr = 1'b0; vld = 1'b0;
    cyc();

    rdy = 1'b0; vld = 1'b1; din = 8'h08;
    cyc();
    din = 8'h28;
    cyc();
    vld = 1'b0;
    chk("mid.two_ready", hi_r, 1'b0);
    chk("mid.errcnt", hi_c, 8'd1);
    rst_n = 1'b0;
    cyc();
    chk("mid.rst_valid", hi_v, 1'b0);
    chk("mid.rst_ready", hi_r, 1'b0);
    chk("mid.rst_errcnt", hi_c, 8'd0);
    rst_n = 1'b1; rdy = 1'b1;
    cyc();
    chk("mid.ready_back", hi_r, 1'b1);
    chk("mid.no_stale", hi_v, 1'b0);
    cyc();
    chk("mid.no_stale2", hi_v, 1'b0);

    repeat (300) begin
      vld = ($urandom_range(0, 3) != 0);
      din = 8'h01 << $urandom_range(0, 7);
      rdy = ($urandom_range(0, 3) != 0);
      cyc();
    end
    vld = 1'b0; rdy = 1'b1;
    repeat (4) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
